// File: rtl/johnson_pkg.sv
// johnson_pkg: shared types and sizing for the Johnson phase monitor
package johnson_pkg;
    localparam int N_DEF   = 4;
    localparam int SEQ_LEN = 2 * N_DEF;
    localparam int PW      = $clog2(SEQ_LEN);
    typedef enum logic [1:0] {SEARCH, TRACK, FAULT} state_e;
    typedef enum logic [1:0] {NONE = 2'b00, ILLEGAL = 2'b01, SKIP = 2'b10} err_code_e;
    function automatic int phase_w(input int n);
        return $clog2(2 * n);
    endfunction
endpackage

// File: rtl/johnson_decode.sv
// johnson_decode: maps a Johnson code to its phase index and flags non-Johnson codes
module johnson_decode #(
    parameter int N  = 4,
    parameter int PW = 3
) (
    input  logic [N-1:0]  code_i,
    output logic          legal_o,
    output logic [PW-1:0] phase_o
);
    logic [N-1:0] inv;
    int           pc;
    assign inv     = code_i[N-1] ? ~code_i : code_i;
    assign legal_o = (inv & (inv + 1'b1)) == '0;
    always_comb begin
        pc = 0;
        for (int i = 0; i < N; i++) pc = pc + int'(code_i[i]);
        phase_o = code_i[N-1] ? PW'(pc - 1) : PW'(2 * N - 1 - pc);
    end
endmodule

// File: rtl/johnson_phase_monitor.sv
// johnson_phase_monitor: locks onto a Johnson down-counter stream, counts revolutions, flags faults
module johnson_phase_monitor
    import johnson_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int REV_W    = 8,
    parameter int LOCK_LEN = 2,
    localparam int PW_L    = phase_w(N),
    localparam int GW      = $clog2(LOCK_LEN + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N-1:0]      code_i,
    input  logic              valid_i,
    input  logic              clear_i,
    output logic [PW_L-1:0]   phase_o,
    output logic              locked_o,
    output logic              wrap_o,
    output logic [REV_W-1:0]  rev_count_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);
    state_e          state_q, state_d;
    err_code_e       err_code_q, err_code_d;
    logic [PW_L-1:0] phase_q, phase_d, ph, nxt;
    logic [GW-1:0]   good_cnt_q, good_cnt_d;
    logic [REV_W-1:0] rev_q, rev_d;
    logic            prev_valid_q, prev_valid_d, wrap_q, wrap_d;
    logic            legal, last, succ, hold;
    johnson_decode #(.N(N), .PW(PW_L)) u_decode (
        .code_i  (code_i),
        .legal_o (legal),
        .phase_o (ph)
    );
    // phase_q doubles as the previous accepted phase whenever prev_valid_q is set
    assign last = phase_q == PW_L'(2 * N - 1);
    assign nxt  = last ? '0 : phase_q + 1'b1;
    assign succ = legal && prev_valid_q && ph == nxt;
    assign hold = legal && prev_valid_q && ph == phase_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= SEARCH;
            err_code_q   <= NONE;
            phase_q      <= '0;
            good_cnt_q   <= '0;
            rev_q        <= '0;
            prev_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_code_q   <= err_code_d;
            phase_q      <= phase_d;
            good_cnt_q   <= good_cnt_d;
            rev_q        <= rev_d;
            prev_valid_q <= prev_valid_d;
            wrap_q       <= wrap_d;
        end
    end
    always_comb begin
        state_d = state_q;
        if (clear_i) state_d = SEARCH;
        else if (valid_i && state_q == SEARCH && succ && good_cnt_q == GW'(LOCK_LEN - 1)) state_d = TRACK;
        else if (valid_i && state_q == TRACK && !succ && !hold) state_d = FAULT;
    end
    always_comb begin
        phase_d      = phase_q;
        prev_valid_d = prev_valid_q;
        good_cnt_d   = good_cnt_q;
        rev_d        = rev_q;
        err_code_d   = err_code_q;
        wrap_d       = 1'b0;
        if (clear_i) begin
            prev_valid_d = 1'b0;
            good_cnt_d   = '0;
            rev_d        = '0;
            err_code_d   = NONE;
        end else if (valid_i && state_q == SEARCH) begin
            if (!legal) begin
                prev_valid_d = 1'b0;
                good_cnt_d   = '0;
            end else if (!prev_valid_q) begin
                phase_d      = ph;
                prev_valid_d = 1'b1;
                good_cnt_d   = '0;
            end else if (succ) begin
                phase_d    = ph;
                good_cnt_d = good_cnt_q + 1'b1;
            end else if (!hold) begin
                phase_d    = ph;
                good_cnt_d = '0;
            end
        end else if (valid_i && state_q == TRACK) begin
            if (succ) begin
                phase_d = ph;
                wrap_d  = last;
                rev_d   = last ? rev_q + 1'b1 : rev_q;
            end else if (!hold) begin
                err_code_d = legal ? SKIP : ILLEGAL;
            end
        end
    end
    assign phase_o     = phase_q;
    assign locked_o    = state_q == TRACK;
    assign wrap_o      = wrap_q;
    assign rev_count_o = rev_q;
    assign err_o       = state_q == FAULT;
    assign err_code_o  = err_code_q;
endmodule

// File: tb/tb_johnson_phase_monitor.sv
// tb_johnson_phase_monitor: directed table, wrap corner sequence and random stream against a behavioural model
module tb_johnson_phase_monitor;
    logic       clk_i = 1'b0, rst_i = 1'b1, valid_i = 1'b0, clear_i = 1'b0;
    logic [3:0] code_i = 4'b0000;
    logic [2:0] phase_o, phase2;
    logic       locked_o, wrap_o, err_o, locked2, wrap2, err2;
    logic [7:0] rev_count_o;
    logic [1:0] rev2, err_code_o, err_code2;
    int errors = 0, checks = 0;
    int seq [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    int m_locked, m_fault, m_phase, m_pv, m_good, m_rev, m_ec, m_wrap;

    always #5 clk_i = ~clk_i;

    johnson_phase_monitor u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .code_i(code_i), .valid_i(valid_i), .clear_i(clear_i),
        .phase_o(phase_o), .locked_o(locked_o), .wrap_o(wrap_o), .rev_count_o(rev_count_o),
        .err_o(err_o), .err_code_o(err_code_o)
    );
    johnson_phase_monitor #(.REV_W(2)) u_dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .code_i(code_i), .valid_i(valid_i), .clear_i(clear_i),
        .phase_o(phase2), .locked_o(locked2), .wrap_o(wrap2), .rev_count_o(rev2),
        .err_o(err2), .err_code_o(err_code2)
    );

    function automatic int find_idx(input logic [3:0] c);
        for (int i = 0; i < 8; i++) if (seq[i] == int'(c)) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int r, input int c, input int v, input logic [3:0] cd);
        int idx;
        bit succ, hold;
        idx    = find_idx(cd);
        succ   = m_pv != 0 && idx == (m_phase + 1) % 8;
        hold   = m_pv != 0 && idx == m_phase;
        m_wrap = 0;
        if (r != 0) begin
            m_locked = 0; m_fault = 0; m_phase = 0; m_pv = 0; m_good = 0; m_rev = 0; m_ec = 0;
        end else if (c != 0) begin
            m_locked = 0; m_fault = 0; m_pv = 0; m_good = 0; m_rev = 0; m_ec = 0;
        end else if (v != 0 && m_fault == 0) begin
            if (m_locked == 0) begin
                if (idx < 0) begin
                    m_pv = 0; m_good = 0;
                end else if (m_pv == 0) begin
                    m_phase = idx; m_pv = 1; m_good = 0;
                end else if (succ) begin
                    m_phase = idx; m_good++;
                    if (m_good == 2) m_locked = 1;
                end else if (!hold) begin
                    m_phase = idx; m_good = 0;
                end
            end else if (succ) begin
                if (m_phase == 7) begin
                    m_wrap = 1; m_rev++;
                end
                m_phase = idx;
            end else if (idx < 0) begin
                m_fault = 1; m_locked = 0; m_ec = 1;
            end else if (!hold) begin
                m_fault = 1; m_locked = 0; m_ec = 2;
            end
        end
    endtask

    task automatic step(input int r, input int c, input int v, input logic [3:0] cd);
        rst_i = r[0]; clear_i = c[0]; valid_i = v[0]; code_i = cd;
        @(posedge clk_i);
        #1;
        model_step(r, c, v, cd);
        chk("locked", locked_o, m_locked);
        chk("phase", phase_o, m_phase);
        chk("wrap", wrap_o, m_wrap);
        chk("rev8", rev_count_o, m_rev % 256);
        chk("rev2", rev2, m_rev % 4);
        chk("err", err_o, m_fault);
        chk("err_code", err_code_o, m_ec);
    endtask

    typedef struct {
        int r, c, v;
        logic [3:0] code;
        int lk, ph, wr, rv, er, ec;
    } vec_t;
    vec_t tbl[$];

    initial begin
        int cur, sel, r, c, v;
        logic [3:0] cd;
        tbl.push_back(vec_t'{1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4'b1000, 0, 0, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4'b1100, 0, 1, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4'b1110, 1, 2, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4'b1111, 1, 3, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4'b0111, 1, 4, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4'b0011, 1, 5, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4'b0001, 1, 6, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4'b0000, 1, 7, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4'b1000, 1, 0, 1, 1, 0, 0});
        tbl.push_back(vec_t'{0, 0, 0, 4'b1000, 1, 0, 0, 1, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4'b1100, 1, 1, 0, 1, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4'b1111, 0, 1, 0, 1, 1, 2});
        tbl.push_back(vec_t'{0, 0, 1, 4'b1000, 0, 1, 0, 1, 1, 2});
        tbl.push_back(vec_t'{0, 1, 1, 4'b1000, 0, 1, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4'b1100, 0, 1, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4'b1110, 0, 2, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4'b1111, 1, 3, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4'b1010, 0, 3, 0, 0, 1, 1});
        tbl.push_back(vec_t'{0, 1, 0, 4'b0000, 0, 3, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4'b0111, 0, 4, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4'b0011, 0, 5, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4'b0001, 1, 6, 0, 0, 0, 0});
        tbl.push_back(vec_t'{1, 1, 1, 4'b0000, 0, 0, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4'b0000, 0, 7, 0, 0, 0, 0});
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].code);
            chk($sformatf("tbl%0d_locked", i), locked_o, tbl[i].lk);
            chk($sformatf("tbl%0d_phase", i), phase_o, tbl[i].ph);
            chk($sformatf("tbl%0d_wrap", i), wrap_o, tbl[i].wr);
            chk($sformatf("tbl%0d_rev", i), rev_count_o, tbl[i].rv);
            chk($sformatf("tbl%0d_err", i), err_o, tbl[i].er);
            chk($sformatf("tbl%0d_code", i), err_code_o, tbl[i].ec);
        end
        // four revolutions with holds: 2-bit counter rolls over to 0
        step(1, 0, 0, 4'b0000);
        for (int i = 0; i < 8; i++) step(0, 0, 1, seq[i][3:0]);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, seq[0][3:0]);
            chk("w5_wrap", wrap_o, 1);
            chk("w5_rev2", rev2, (k + 1) % 4);
            chk("w5_rev8", rev_count_o, k + 1);
            for (int i = 1; i < 8; i++) begin
                step(0, 0, 1, seq[i][3:0]);
                chk("w5_wrap_low", wrap_o, 0);
                step(0, 0, 1, seq[i][3:0]);
                step(0, 0, 0, seq[i][3:0]);
            end
            chk("w5_err", err_o, 0);
            chk("w5_locked", locked_o, 1);
        end
        step(1, 0, 0, 4'b0000);
        cur = 7;
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 199) == 0);
            c = int'($urandom_range(0, 99) == 0);
            v = int'($urandom_range(0, 9) != 0);
            sel = int'($urandom_range(0, 19));
            if (sel < 14) cd = seq[(cur + 1) % 8][3:0];
            else if (sel < 16) cd = seq[cur][3:0];
            else if (sel < 18) cd = seq[$urandom_range(0, 7)][3:0];
            else cd = 4'($urandom_range(0, 15));
            if (find_idx(cd) >= 0) cur = find_idx(cd);
            step(r, c, v, cd);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
